// File: rtl/mapper_slot_ctrl_if.sv
// Z80 bus as seen by the slot/mapper controller: CPU strobes in, read data and bus claim out.
interface mapper_slot_ctrl_if;
    logic [15:0] addr;
    logic [7:0]  d_from_cpu;
    logic        wr_n;
    logic        rd_n;
    logic        iorq_n;
    logic        mreq_n;
    logic        m1_n;
    logic        rfrsh_n;
    logic [7:0]  d_to_cpu;
    logic        dataBusRQ;

    modport master (
        output addr, d_from_cpu, wr_n, rd_n, iorq_n, mreq_n, m1_n, rfrsh_n,
        input  d_to_cpu, dataBusRQ
    );

    modport slave (
        input  addr, d_from_cpu, wr_n, rd_n, iorq_n, mreq_n, m1_n, rfrsh_n,
        output d_to_cpu, dataBusRQ
    );
endinterface

// File: rtl/mapper_slot_ctrl.sv
// MSX primary/secondary slot selection (port A8h, FFFFh) plus memory mapper segment
// registers (ports FCh-FFh) with size-dependent masking of bank and readback.
module mapper_slot_ctrl #(
    parameter int          SEG_BITS = 8,
    parameter logic [3:0]  EXPANDED = 4'b1000,
    parameter logic [31:0] RST_SEG  = {8'd0, 8'd1, 8'd2, 8'd3}
) (
    input  logic                    clk21m,
    input  logic                    reset,
    mapper_slot_ctrl_if.slave       bus,
    input  logic [3:0]              ram_seg_log2,
    output logic [SEG_BITS-1:0]     ram_bank,
    output logic [1:0]              slot,
    output logic [1:0]              sub_slot,
    output logic [3:0]              SLTSL_n
);
    localparam logic [3:0] SEG_MAX = 4'(SEG_BITS);

    logic [1:0]          page;
    logic                ack;
    logic                req;
    logic                io_en, ppi_en, mpr_en, ssl_en;
    logic                ppi_we, mpr_we, ssl_we;
    logic [7:0]          psl;
    logic [7:0]          ssl [4];
    logic [SEG_BITS-1:0] seg [4];
    logic [3:0]          eff;
    logic [7:0]          mask;
    logic [7:0]          seg_ext;
    logic [7:0]          mpr_rd;

    assign page = bus.addr[15:14];

    // ack blocks req after the first clock of a bus cycle, so each write commits once
    assign req = (~bus.iorq_n | ~bus.mreq_n) & (~bus.wr_n | ~bus.rd_n) & ~ack;

    always_ff @(posedge clk21m) begin
        if (reset)
            ack <= 1'b0;
        else if (bus.iorq_n && bus.mreq_n)
            ack <= 1'b0;
        else if (req)
            ack <= 1'b1;
    end

    // interrupt-acknowledge cycles (m1_n low with iorq_n) are not port accesses
    assign io_en  = ~bus.iorq_n & bus.m1_n;
    assign ppi_en = io_en & (bus.addr[7:0] == 8'hA8);
    assign mpr_en = io_en & (bus.addr[7:2] == 6'b111111);
    assign ssl_en = ~bus.mreq_n & bus.rfrsh_n & (bus.addr == 16'hFFFF) & EXPANDED[psl[7:6]];

    assign ppi_we = ppi_en & ~bus.wr_n & req;
    assign mpr_we = mpr_en & ~bus.wr_n & req;
    assign ssl_we = ssl_en & ~bus.wr_n & req;

    always_ff @(posedge clk21m) begin
        if (reset)
            psl <= 8'h00;
        else if (ppi_we)
            psl <= bus.d_from_cpu;
    end

    // only expanded slots get a secondary slot register; the rest read as zero
    for (genvar k = 0; k < 4; k++) begin : g_ssl
        if (EXPANDED[k]) begin : g_reg
            logic [7:0] r;
            always_ff @(posedge clk21m) begin
                if (reset)
                    r <= 8'h00;
                else if (ssl_we && psl[7:6] == 2'(k))
                    r <= bus.d_from_cpu;
            end
            assign ssl[k] = r;
        end else begin : g_zero
            assign ssl[k] = 8'h00;
        end
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            for (int p = 0; p < 4; p++)
                seg[p] <= RST_SEG[8*p +: SEG_BITS];
        end else if (mpr_we) begin
            seg[bus.addr[1:0]] <= bus.d_from_cpu[SEG_BITS-1:0];
        end
    end

    always_comb begin
        eff = ram_seg_log2;
        if (ram_seg_log2 < 4'd2)
            eff = 4'd2;
        else if (ram_seg_log2 > SEG_MAX)
            eff = SEG_MAX;
    end

    // mask is applied on the fly so a RAM size change needs no register rewrite
    assign mask     = 8'hFF << eff;
    assign ram_bank = seg[page] & ~mask[SEG_BITS-1:0];

    always_comb begin
        seg_ext = 8'h00;
        seg_ext[SEG_BITS-1:0] = seg[bus.addr[1:0]];
    end

    assign mpr_rd = (seg_ext & ~mask) | mask;

    assign slot     = psl[2*page +: 2];
    assign sub_slot = EXPANDED[slot] ? ssl[slot][2*page +: 2] : 2'b00;

    always_comb begin
        for (int k = 0; k < 4; k++)
            SLTSL_n[k] = ~((slot == 2'(k)) & ~bus.mreq_n & bus.rfrsh_n);
    end

    always_comb begin
        bus.d_to_cpu = 8'hFF;
        if (bus.rd_n)
            bus.d_to_cpu = 8'hFF;
        else if (mpr_en)
            bus.d_to_cpu = mpr_rd;
        else if (ppi_en)
            bus.d_to_cpu = psl;
        else if (ssl_en)
            bus.d_to_cpu = ~ssl[psl[7:6]];
    end

    assign bus.dataBusRQ = ~bus.rd_n & (mpr_en | ppi_en | ssl_en);
endmodule

// File: tb/tb_mapper_slot_ctrl.sv
// Directed bench for mapper_slot_ctrl: slot/sub-slot select, mapper masking, single commit, reset.
module tb_mapper_slot_ctrl;
    logic       clk21m = 1'b0;
    logic       reset;
    logic [3:0] ram_seg_log2;
    logic [7:0] ram_bank;
    logic [1:0] slot;
    logic [1:0] sub_slot;
    logic [3:0] SLTSL_n;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] rd;
    logic       rq;

    mapper_slot_ctrl_if bus ();

    mapper_slot_ctrl dut (
        .clk21m       (clk21m),
        .reset        (reset),
        .bus          (bus),
        .ram_seg_log2 (ram_seg_log2),
        .ram_bank     (ram_bank),
        .slot         (slot),
        .sub_slot     (sub_slot),
        .SLTSL_n      (SLTSL_n)
    );

    always #5 clk21m = ~clk21m;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk21m);
        #1;
    endtask

    task automatic idle();
        bus.wr_n    = 1'b1;
        bus.rd_n    = 1'b1;
        bus.iorq_n  = 1'b1;
        bus.mreq_n  = 1'b1;
        bus.m1_n    = 1'b1;
        bus.rfrsh_n = 1'b1;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr = {8'h00, a}; bus.d_from_cpu = d;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d, output logic q);
        bus.addr = {8'h00, a};
        bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        #1;
        d = bus.d_to_cpu; q = bus.dataBusRQ;
        tick();
        idle();
        tick();
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
        bus.addr = a; bus.d_from_cpu = d;
        bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic mem_rd(input logic [15:0] a, output logic [7:0] d, output logic q);
        bus.addr = a;
        bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        #1;
        d = bus.d_to_cpu; q = bus.dataBusRQ;
        tick();
        idle();
        tick();
    endtask

    initial begin
        idle();
        bus.addr = 16'h0000; bus.d_from_cpu = 8'h00;
        ram_seg_log2 = 4'd8;
        reset = 1'b1;
        tick(2);

        // reset state, outputs straight from reset values
        chk("rst_sltsl", 16'(SLTSL_n), 16'hF);
        chk("rst_bank_p0", 16'(ram_bank), 16'h03);
        chk("rst_slot", 16'(slot), 16'h0);
        chk("rst_dout", 16'(bus.d_to_cpu), 16'hFF);
        chk("rst_rq", 16'(bus.dataBusRQ), 16'h0);
        bus.addr = 16'hC000; #1;
        chk("rst_bank_p3", 16'(ram_bank), 16'h00);
        reset = 1'b0;
        tick();

        io_rd(8'hFC, rd, rq); chk("rst_seg0", 16'(rd), 16'h03);
        io_rd(8'hFF, rd, rq); chk("rst_seg3", 16'(rd), 16'h00);
        io_rd(8'hA8, rd, rq); chk("rst_psl", 16'(rd), 16'h00);
        chk("psl_rq", 16'(rq), 16'h1);

        // mapper readback with masking
        ram_seg_log2 = 4'd3;
        io_wr(8'hFE, 8'h2D);
        io_rd(8'hFE, rd, rq);
        chk("mpr_rd_fe", 16'(rd), 16'hFD);
        chk("mpr_rq", 16'(rq), 16'h1);
        bus.addr = 16'h8000; #1;
        chk("bank_8000", 16'(ram_bank), 16'h05);

        // long write, data changes mid-cycle: only the first clock commits
        ram_seg_log2 = 4'd8;
        bus.addr = 16'h00FC; bus.d_from_cpu = 8'h11;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        bus.d_from_cpu = 8'h22;
        tick(3);
        idle();
        tick();
        io_rd(8'hFC, rd, rq);
        chk("single_commit", 16'(rd), 16'h11);

        // secondary slot register
        io_wr(8'hA8, 8'hC0);
        mem_wr(16'hFFFF, 8'h39);
        mem_rd(16'hFFFF, rd, rq);
        chk("ssl_rd", 16'(rd), 16'hC6);
        chk("ssl_rq", 16'(rq), 16'h1);
        bus.addr = 16'h4000; #1;
        chk("slot_4000", 16'(slot), 16'h0);
        chk("sub_4000", 16'(sub_slot), 16'h0);
        bus.addr = 16'hC000; #1;
        chk("slot_c000", 16'(slot), 16'h3);
        chk("sub_c000", 16'(sub_slot), 16'h0);
        bus.mreq_n = 1'b0; #1;
        chk("sltsl_c000", 16'(SLTSL_n), 16'h7);
        bus.rfrsh_n = 1'b0; #1;
        chk("sltsl_rfrsh", 16'(SLTSL_n), 16'hF);
        idle();
        tick();

        // non-expanded target slot: no claim, no write
        io_wr(8'hA8, 8'h40);
        mem_rd(16'hFFFF, rd, rq);
        chk("nexp_rq", 16'(rq), 16'h0);
        chk("nexp_rd", 16'(rd), 16'hFF);
        mem_wr(16'hFFFF, 8'hAA);
        io_wr(8'hA8, 8'hC0);
        mem_rd(16'hFFFF, rd, rq);
        chk("ssl3_kept", 16'(rd), 16'hC6);

        mem_wr(16'hFFFF, 8'h9C);
        bus.addr = 16'hC000; #1;
        chk("sub_c000_b", 16'(sub_slot), 16'h2);
        bus.addr = 16'h8000; #1;
        chk("sub_8000_b", 16'(sub_slot), 16'h0);

        // interrupt acknowledge must not look like a port read
        bus.addr = 16'h00FE; bus.iorq_n = 1'b0; bus.m1_n = 1'b0; bus.rd_n = 1'b0; #1;
        chk("m1_rq", 16'(bus.dataBusRQ), 16'h0);
        chk("m1_rd", 16'(bus.d_to_cpu), 16'hFF);
        tick();
        idle();
        tick();

        // RAM size change acts combinationally on bank and readback
        io_wr(8'hFD, 8'h1F);
        ram_seg_log2 = 4'd5;
        bus.addr = 16'h4000; #1;
        chk("bank_sz5", 16'(ram_bank), 16'h1F);
        io_rd(8'hFD, rd, rq); chk("rd_1f_sz5", 16'(rd), 16'hFF);
        ram_seg_log2 = 4'd2;
        bus.addr = 16'h4000; #1;
        chk("bank_sz2", 16'(ram_bank), 16'h03);
        io_rd(8'hFD, rd, rq); chk("rd_1f_sz2", 16'(rd), 16'hFF);
        io_wr(8'hFD, 8'h05);
        ram_seg_log2 = 4'd5;
        io_rd(8'hFD, rd, rq); chk("rd_05_sz5", 16'(rd), 16'hE5);
        ram_seg_log2 = 4'd2;
        io_rd(8'hFD, rd, rq); chk("rd_05_sz2", 16'(rd), 16'hFD);
        ram_seg_log2 = 4'd0;
        io_rd(8'hFD, rd, rq); chk("clamp_lo", 16'(rd), 16'hFD);
        ram_seg_log2 = 4'd15;
        io_rd(8'hFD, rd, rq); chk("clamp_hi", 16'(rd), 16'h05);

        // reset during an active psl write
        bus.addr = 16'h00A8; bus.d_from_cpu = 8'h55;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        chk("ack_set", 16'(dut.ack), 16'h1);
        reset = 1'b1;
        tick();
        chk("ack_rst", 16'(dut.ack), 16'h0);
        reset = 1'b0;
        idle();
        tick();
        io_rd(8'hA8, rd, rq); chk("psl_after_rst", 16'(rd), 16'h00);

        // write arriving on the reset clock is dropped
        bus.addr = 16'h00A8; bus.d_from_cpu = 8'h33;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        tick();
        io_rd(8'hA8, rd, rq); chk("wr_on_rst", 16'(rd), 16'h00);

        // write held across reset release commits once afterwards
        bus.addr = 16'h00A8; bus.d_from_cpu = 8'h55;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.d_from_cpu = 8'h77;
        tick();
        bus.d_from_cpu = 8'h99;
        tick(2);
        idle();
        tick();
        io_rd(8'hA8, rd, rq); chk("wr_after_rst", 16'(rd), 16'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mapper_slot_ctrl.md
MAPPER_SLOT_CTRL -- requirements
Module: mapper_slot_ctrl

Interface
REQ-001 The block SHALL have parameter SEG_BITS, default 8, meaning segment register width, legal range 2..8.
REQ-002 The block SHALL have parameter EXPANDED, default 4'b1000, meaning a bitmask of primary slots carrying a sub-slot register.
REQ-003 The block SHALL have parameter RST_SEG, default {8'd0,8'd1,8'd2,8'd3}, meaning the reset segments for pages 3..0.
REQ-004 The block SHALL have these ports:
  clk21m  in  1  system clock
  reset  in  1  synchronous, active-high reset
  addr  in  16  CPU address
  d_from_cpu  in  8  CPU write data
  wr_n, rd_n, iorq_n, mreq_n, m1_n, rfrsh_n  in  1 each  Z80 strobes
  ram_seg_log2  in  4  number of valid segment bits (RAM size = 16 kB << value)
  d_to_cpu  out  8  read data
  dataBusRQ  out  1  block drives the data bus
  ram_bank  out  SEG_BITS  segment for the current page
  slot  out  2  primary slot of the current page
  sub_slot  out  2  sub-slot of the current page
  SLTSL_n  out  4  primary slot selects, active low

Function
REQ-005 page SHALL equal addr[15:14].
REQ-006 req SHALL equal (~iorq_n|~mreq_n) & (~wr_n|~rd_n) & ~ack.
REQ-007 ack SHALL set on the clock after req=1 and SHALL clear when iorq_n=1 and mreq_n=1.
REQ-008 Every register write SHALL commit exactly once per bus cycle, on the req clock, however long wr_n stays low.
REQ-009 I/O decode SHALL require ~iorq_n & m1_n; ppi_en SHALL decode addr[7:0]=A8h and mpr_en SHALL decode addr[7:2]=6'b111111.
REQ-010 psl[7:0] SHALL be written on ppi_en & ~wr_n & req.
REQ-011 slot SHALL equal psl[2*page+1:2*page].
REQ-012 ssl_en SHALL equal ~mreq_n & rfrsh_n & addr=FFFFh & EXPANDED[psl[7:6]].
REQ-013 On ssl_en & ~wr_n & req, ssl[psl[7:6]] SHALL load d_from_cpu.
REQ-014 Reads of FFFFh SHALL return ~ssl[psl[7:6]] only when ssl_en is true; otherwise the block SHALL not claim the bus.
REQ-015 sub_slot SHALL equal ssl[slot][2*page+1:2*page] when EXPANDED[slot]=1, else 2'b00.
REQ-016 SLTSL_n[k] SHALL equal ~(slot==k & ~mreq_n & rfrsh_n).
REQ-017 eff SHALL equal ram_seg_log2 clamped to 2..SEG_BITS.
REQ-018 mask SHALL be 8 bits with bits [7:eff] set.
REQ-019 On mpr_en & ~wr_n & req, seg[addr[1:0]] SHALL load d_from_cpu[SEG_BITS-1:0].
REQ-020 ram_bank SHALL equal seg[page] & ~mask[SEG_BITS-1:0], so a ram_seg_log2 change takes effect combinationally without rewriting registers.
REQ-021 Mapper readback SHALL equal zero-extended (seg[addr[1:0]] & ~mask) | mask.
REQ-022 d_to_cpu SHALL be selected by priority:
  - rd_n=1 -> FFh
  - mpr_en -> mapper readback
  - ppi_en -> psl
  - ssl_en -> ~ssl
  - otherwise -> FFh
REQ-023 dataBusRQ SHALL equal ~rd_n & (mpr_en|ppi_en|ssl_en).
REQ-024 After a psl write, the FFFFh target slot SHALL take the new psl[7:6] from the next bus cycle on.
REQ-025 Registers for slots with EXPANDED[k]=0 SHALL not be implemented and SHALL read as 0.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set psl=00h, every ssl=00h, seg[p]=RST_SEG[p] and ack=0.
REQ-027 A write coinciding with a reset clock SHALL be discarded.
REQ-028 Reset mid-bus-cycle SHALL clear ack, so a write still asserted after reset releases SHALL commit once.
REQ-029 Outputs SHALL be combinational from the reset values, e.g. with all strobes high: SLTSL_n=4'hF, ram_bank=RST_SEG[page], slot=0.

Verification
REQ-030 Mapper readback with defaults: reset, ram_seg_log2=3, write 2Dh to port FEh, read FEh -> F8h|05h=FDh; addr=8000h -> ram_bank=05h.
REQ-031 Single-commit write: hold wr_n low for 6 clocks on port FCh with data changing 11h->22h mid-cycle -> seg[0]=11h.
REQ-032 Sub-slot register: write psl=C0h, write 39h to FFFFh, read FFFFh -> C6h with dataBusRQ=1; addr=4000h -> slot=0, sub_slot=0; addr=C000h -> slot=3, sub_slot=0.
REQ-033 Non-expanded slot: psl=40h, read FFFFh -> dataBusRQ=0, d_to_cpu=FFh, and ssl[3] unchanged.
REQ-034 Size change: seg[1]=1Fh, ram_seg_log2 toggled 5->2 -> ram_bank at 4000h changes 1Fh->03h, and FDh read changes FFh->FFh/FFh (masking check with seg[1]=1Fh: 5 -> FFh, 2 -> FFh; then seg[1]=05h: 5 -> E5h, 2 -> FDh).
REQ-035 Reset mid-write: assert reset during an active write to A8h -> psl=00h after reset, and ack=0.
